// File: rtl/ss_sequencer_pkg.sv
// Save-state sequencer shared definitions: ss_ctrl field map,
// direction codes and FSM state encodings.
package ss_sequencer_pkg;

    localparam int SS_ADDR_W  = 8;
    localparam int BW_SS_CTRL = 3 + SS_ADDR_W + 8;

    // ss_ctrl = {ss_act, ss_we, ss_oe, ss_addr, ss_wdat}
    localparam int SS_WDAT_LSB = 0;
    localparam int SS_WDAT_MSB = 7;
    localparam int SS_ADDR_LSB = 8;
    localparam int SS_ADDR_MSB = SS_ADDR_LSB + SS_ADDR_W - 1;
    localparam int SS_OE       = SS_ADDR_MSB + 1;
    localparam int SS_WE       = SS_OE + 1;
    localparam int SS_ACT      = SS_WE + 1;

    localparam logic SS_DIR_SAVE = 1'b0;
    localparam logic SS_DIR_RST  = 1'b1;

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_SETTLE_IN  = 4'd1;
    localparam logic [3:0] ST_RD_REQ     = 4'd2;
    localparam logic [3:0] ST_RD_WAIT    = 4'd3;
    localparam logic [3:0] ST_RD_PUSH    = 4'd4;
    localparam logic [3:0] ST_WR_GET     = 4'd5;
    localparam logic [3:0] ST_WR_STB     = 4'd6;
    localparam logic [3:0] ST_SETTLE_OUT = 4'd7;
    localparam logic [3:0] ST_FIN        = 4'd8;

    function automatic int ss_ctrl_w(input int aw);
        return aw + 11;
    endfunction

endpackage

// File: rtl/ss_delay_cnt.sv
// Loadable down-counter with zero flag, reused for every wait
// interval of the save-state sequencer.
module ss_delay_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ss_sequencer.sv
// Save-state sequencer: freezes the mapper and streams its
// register file out to the MCU (save) or back in (restore).
module ss_sequencer
    import ss_sequencer_pkg::*;
#(
    parameter int ADDR_W = SS_ADDR_W,
    parameter int RD_LAT = 2,
    parameter int SETTLE = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_start,
    input  logic                         cmd_dir,
    input  logic [ADDR_W:0]              cmd_len,
    input  logic                         cmd_abort,
    output logic [7:0]                   sv_dat,
    output logic                         sv_vld,
    input  logic                         sv_rdy,
    input  logic [7:0]                   rs_dat,
    input  logic                         rs_vld,
    output logic                         rs_rdy,
    output logic [ss_ctrl_w(ADDR_W)-1:0] ss_ctrl,
    input  logic [7:0]                   ss_rdat,
    output logic                         busy,
    output logic                         done,
    output logic                         aborted
);

    localparam int CNT_MAX = (SETTLE > RD_LAT) ? SETTLE : RD_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] LD_SET = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] LD_RD  = CNT_W'(RD_LAT - 1);

    logic [3:0]        r_st;
    logic              r_dir;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_idx;
    logic              r_run;
    logic              r_we;
    logic              r_oe;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdat;
    logic [7:0]        r_sv_dat;
    logic              r_sv_vld;
    logic              r_rs_rdy;
    logic              r_done;
    logic              r_abt;
    logic              r_aborted;

    logic [3:0]        w_nx;
    logic [ADDR_W:0]   w_idx_n;
    logic [ADDR_W:0]   w_idx_inc;
    logic              w_last;
    logic              w_ld;
    logic [CNT_W-1:0]  w_ldv;
    logic              w_zero;
    logic              w_abt_take;
    logic              w_strobe;

    assign w_idx_inc = r_idx + 1'b1;
    assign w_last    = (w_idx_inc == r_len);

    always_comb begin
        w_nx    = r_st;
        w_idx_n = r_idx;
        unique case (1'b1)
            (r_st == ST_IDLE): begin
                if (cmd_start) begin
                    w_nx    = (cmd_len == '0) ? ST_FIN : ST_SETTLE_IN;
                    w_idx_n = '0;
                end
            end
            (r_st == ST_SETTLE_IN): begin
                if (cmd_abort)
                    w_nx = ST_SETTLE_OUT;
                else if (w_zero)
                    w_nx = (r_dir == SS_DIR_RST) ? ST_WR_GET : ST_RD_REQ;
            end
            (r_st == ST_RD_REQ): begin
                w_nx = cmd_abort ? ST_SETTLE_OUT : ST_RD_WAIT;
            end
            (r_st == ST_RD_WAIT): begin
                if (cmd_abort)
                    w_nx = ST_SETTLE_OUT;
                else if (w_zero)
                    w_nx = ST_RD_PUSH;
            end
            (r_st == ST_RD_PUSH): begin
                // A handshake in the abort cycle still counts.
                if (sv_rdy) begin
                    w_idx_n = w_idx_inc;
                    w_nx    = (w_last || cmd_abort) ? ST_SETTLE_OUT
                                                    : ST_RD_REQ;
                end else if (cmd_abort) begin
                    w_nx = ST_SETTLE_OUT;
                end
            end
            (r_st == ST_WR_GET): begin
                if (cmd_abort)
                    w_nx = ST_SETTLE_OUT;
                else if (rs_vld)
                    w_nx = ST_WR_STB;
            end
            (r_st == ST_WR_STB): begin
                w_idx_n = w_idx_inc;
                w_nx    = (w_last || cmd_abort) ? ST_SETTLE_OUT : ST_WR_GET;
            end
            (r_st == ST_SETTLE_OUT): begin
                if (w_zero)
                    w_nx = ST_FIN;
            end
            (r_st == ST_FIN): begin
                w_nx = ST_IDLE;
            end
            default: begin
                w_nx = ST_IDLE;
            end
        endcase
    end

    assign w_ld = (w_nx != r_st) &&
                  ((w_nx == ST_SETTLE_IN) || (w_nx == ST_SETTLE_OUT) ||
                   (w_nx == ST_RD_WAIT));
    assign w_ldv = (w_nx == ST_RD_WAIT) ? LD_RD : LD_SET;

    assign w_abt_take = cmd_abort && (w_nx == ST_SETTLE_OUT) &&
                        (r_st != ST_SETTLE_OUT);
    assign w_strobe   = (w_nx == ST_RD_REQ) || (w_nx == ST_WR_STB);

    ss_delay_cnt #(
        .W(CNT_W)
    ) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .i_load(w_ld),
        .i_val (w_ldv),
        .o_zero(w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st      <= ST_IDLE;
            r_dir     <= SS_DIR_SAVE;
            r_len     <= '0;
            r_idx     <= '0;
            r_run     <= 1'b0;
            r_we      <= 1'b0;
            r_oe      <= 1'b0;
            r_addr    <= '0;
            r_wdat    <= '0;
            r_sv_dat  <= '0;
            r_sv_vld  <= 1'b0;
            r_rs_rdy  <= 1'b0;
            r_done    <= 1'b0;
            r_abt     <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_st     <= w_nx;
            r_idx    <= w_idx_n;
            r_run    <= (w_nx != ST_IDLE) && (w_nx != ST_FIN);
            r_oe     <= (w_nx == ST_RD_REQ);
            r_we     <= (w_nx == ST_WR_STB);
            r_addr   <= w_strobe ? w_idx_n[ADDR_W-1:0] : '0;
            r_wdat   <= (w_nx == ST_WR_STB) ? rs_dat : 8'h00;
            r_sv_vld <= (w_nx == ST_RD_PUSH);
            r_rs_rdy <= (w_nx == ST_WR_GET);
            r_done   <= (w_nx == ST_FIN);
            if (r_st == ST_RD_WAIT && w_nx == ST_RD_PUSH)
                r_sv_dat <= ss_rdat;
            if (r_st == ST_IDLE && cmd_start) begin
                r_dir     <= cmd_dir;
                r_len     <= cmd_len;
                r_abt     <= 1'b0;
                r_aborted <= 1'b0;
            end else begin
                if (w_abt_take)
                    r_abt <= 1'b1;
                if (w_nx == ST_FIN && r_abt)
                    r_aborted <= 1'b1;
            end
        end
    end

    assign ss_ctrl = {r_run, r_we, r_oe, r_addr, r_wdat};
    assign sv_dat  = r_sv_dat;
    assign sv_vld  = r_sv_vld;
    assign rs_rdy  = r_rs_rdy;
    assign busy    = r_run;
    assign done    = r_done;
    assign aborted = r_aborted;

endmodule

// File: tb/tb_ss_sequencer.sv
// Bench for ss_sequencer: randomized save/restore traffic against a
// latency-accurate mapper model and a transaction-level reference.
module tb_ss_sequencer;
    import ss_sequencer_pkg::*;

    localparam int AW  = 8;
    localparam int RDL = 2;
    localparam int STL = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            cmd_start = 1'b0;
    logic            cmd_dir = 1'b0;
    logic [AW:0]     cmd_len = '0;
    logic            cmd_abort = 1'b0;
    logic [7:0]      sv_dat;
    logic            sv_vld;
    logic            sv_rdy = 1'b0;
    logic [7:0]      rs_dat = 8'h00;
    logic            rs_vld = 1'b0;
    logic            rs_rdy;
    logic [BW_SS_CTRL-1:0] ss_ctrl;
    logic [7:0]      ss_rdat;
    logic            busy;
    logic            done;
    logic            aborted;

    ss_sequencer #(.ADDR_W(AW), .RD_LAT(RDL), .SETTLE(STL)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start),
        .cmd_dir(cmd_dir), .cmd_len(cmd_len), .cmd_abort(cmd_abort),
        .sv_dat(sv_dat), .sv_vld(sv_vld), .sv_rdy(sv_rdy),
        .rs_dat(rs_dat), .rs_vld(rs_vld), .rs_rdy(rs_rdy),
        .ss_ctrl(ss_ctrl), .ss_rdat(ss_rdat), .busy(busy),
        .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    logic          s_act, s_we, s_oe;
    logic [AW-1:0] s_addr;
    logic [7:0]    s_wdat;
    assign s_act  = ss_ctrl[SS_ACT];
    assign s_we   = ss_ctrl[SS_WE];
    assign s_oe   = ss_ctrl[SS_OE];
    assign s_addr = ss_ctrl[SS_ADDR_MSB:SS_ADDR_LSB];
    assign s_wdat = ss_ctrl[SS_WDAT_MSB:SS_WDAT_LSB];

    // Mapper: data for a sampled ss_oe is valid RD_LAT cycles after
    // the strobe appears, for one cycle only; otherwise filler.
    logic [7:0] m_pipe = 8'hEE;
    logic [7:0] m_rdat = 8'hEE;
    assign ss_rdat = m_rdat;
    always @(posedge clk) begin
        m_pipe <= s_oe ? 8'(8'hA0 + s_addr) : 8'hEE;
        m_rdat <= m_pipe;
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int st_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] oe_q[$];
    logic [7:0] we_a[$];
    logic [7:0] we_d[$];
    logic [7:0] sv_q[$];
    int   act_cyc, first_act, first_oe, first_vld, last_act;
    int   done_cnt, done_cyc, prot_err, rsrdy_we, hold_err;
    logic done_ab, p_oe, p_vld, p_hs;
    logic [7:0] p_dat;
    logic clr = 1'b0;

    always @(negedge clk) begin
        if (clr || !rst_n) begin
            oe_q.delete(); we_a.delete(); we_d.delete(); sv_q.delete();
            act_cyc <= 0; first_act <= -1; first_oe <= -1;
            first_vld <= -1; last_act <= -1; done_cnt <= 0;
            done_cyc <= -1; prot_err <= 0; rsrdy_we <= 0;
            hold_err <= 0; done_ab <= 1'b0; p_oe <= 1'b0;
            p_vld <= 1'b0; p_hs <= 1'b0; p_dat <= 8'h00;
        end else begin
            if (s_act) begin
                act_cyc <= act_cyc + 1;
                last_act <= cyc;
                if (first_act < 0) first_act <= cyc;
            end
            if (s_oe) begin
                oe_q.push_back(s_addr);
                if (first_oe < 0) first_oe <= cyc;
            end
            if (s_we) begin
                we_a.push_back(s_addr);
                we_d.push_back(s_wdat);
            end
            if ((s_oe && s_we) || ((s_oe || s_we) && !s_act) ||
                (s_oe && p_oe) ||
                (!s_oe && !s_we && (s_addr != 0 || s_wdat != 0)))
                prot_err <= prot_err + 1;
            if (s_we && rs_rdy) rsrdy_we <= rsrdy_we + 1;
            if (sv_vld && first_vld < 0) first_vld <= cyc;
            if (sv_vld && sv_rdy) sv_q.push_back(sv_dat);
            if (p_vld && !p_hs && sv_vld && sv_dat != p_dat)
                hold_err <= hold_err + 1;
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
                done_ab <= aborted;
            end
            p_oe <= s_oe;
            p_vld <= sv_vld;
            p_hs <= sv_vld && sv_rdy;
            p_dat <= sv_dat;
        end
    end

    task automatic clear_mon();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
    endtask

    task automatic start_cmd(input logic dir, input int len);
        @(posedge clk); #1;
        cmd_start = 1'b1;
        cmd_dir = dir;
        cmd_len = (AW+1)'(len);
        st_cyc = cyc;
        @(posedge clk); #1;
        cmd_start = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({ss_ctrl, sv_dat, sv_vld, rs_rdy, busy, done, aborted} !== '0) begin
            bad++;
            $display("FAIL reset_async: ctrl=%h busy=%b done=%b want 0",
                     ss_ctrl, busy, done);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if ({ss_ctrl, sv_vld, rs_rdy, busy, done, aborted} !== '0 ||
            done_cnt != 0) begin
            bad++;
            $display("FAIL reset_idle: ctrl=%h done_cnt=%0d want 0",
                     ss_ctrl, done_cnt);
        end
    endtask

    task automatic test_save(input int len, input bit rnd, input string nm);
        int m;
        clear_mon();
        sv_rdy = !rnd;
        start_cmd(SS_DIR_SAVE, len);
        for (int c = 0; c < len * 30 + 200 && done_cnt == 0; c++) begin
            @(posedge clk); #1;
            if (rnd) sv_rdy = ($urandom_range(0, 3) != 0);
        end
        sv_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (sv_q.size() != len) begin
            bad++;
            $display("FAIL %s_bytes: got %0d want %0d", nm, sv_q.size(), len);
        end
        m = -1;
        for (int i = 0; i < sv_q.size() && i < len; i++)
            if (m < 0 && sv_q[i] !== 8'(8'hA0 + i)) m = i;
        total++;
        if (m >= 0) begin
            bad++;
            $display("FAIL %s_data[%0d]: got %h want %h", nm, m, sv_q[m],
                     8'(8'hA0 + m));
        end
        m = (oe_q.size() != len) ? 999 : -1;
        for (int i = 0; i < oe_q.size() && i < len; i++)
            if (m < 0 && oe_q[i] !== 8'(i)) m = i;
        total++;
        if (m >= 0) begin
            bad++;
            $display("FAIL %s_oe_addr: idx=%0d n=%0d want n=%0d", nm, m,
                     oe_q.size(), len);
        end
        total++;
        if (done_cnt != 1 || done_ab !== 1'b0 || we_a.size() != 0) begin
            bad++;
            $display("FAIL %s_done: cnt=%0d ab=%b we=%0d want 1 0 0", nm,
                     done_cnt, done_ab, we_a.size());
        end
        total++;
        if (prot_err != 0 || hold_err != 0) begin
            bad++;
            $display("FAIL %s_protocol: prot=%0d hold=%0d want 0 0", nm,
                     prot_err, hold_err);
        end
        total++;
        if (first_act - st_cyc != 1 || first_oe - st_cyc != STL + 1 ||
            first_vld - st_cyc != STL + RDL + 2) begin
            bad++;
            $display("FAIL %s_timing: act=%0d oe=%0d vld=%0d want 1 %0d %0d",
                     nm, first_act - st_cyc, first_oe - st_cyc,
                     first_vld - st_cyc, STL + 1, STL + RDL + 2);
        end
        total++;
        if (done_cyc != last_act + 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_release: done_cyc=%0d want %0d", nm, done_cyc,
                     last_act + 1);
        end
        if (!rnd) begin
            total++;
            if (act_cyc != 2 * STL + len * (RDL + 2)) begin
                bad++;
                $display("FAIL %s_act_span: got %0d want %0d", nm, act_cyc,
                         2 * STL + len * (RDL + 2));
            end
        end
    endtask

    task automatic test_restore(input int len, input bit fixed, input string nm);
        logic [7:0] dq[$];
        int k, m;
        bit hs;
        for (int i = 0; i < len; i++)
            dq.push_back(fixed ? 8'(8'h11 * (i + 1)) : 8'($urandom_range(0, 255)));
        clear_mon();
        start_cmd(SS_DIR_RST, len);
        k = 0;
        for (int c = 0; c < len * 20 + 200 && done_cnt == 0; c++) begin
            @(negedge clk);
            hs = rs_vld && rs_rdy;
            @(posedge clk); #1;
            if (hs) begin
                k++;
                rs_vld = 1'b0;
            end
            if (!rs_vld && k < len && $urandom_range(0, 2) != 0) begin
                rs_vld = 1'b1;
                rs_dat = dq[k];
            end
        end
        rs_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        m = (we_a.size() != len || k != len) ? 999 : -1;
        for (int i = 0; i < we_a.size() && i < len; i++)
            if (m < 0 && (we_a[i] !== 8'(i) || we_d[i] !== dq[i])) m = i;
        total++;
        if (m >= 0) begin
            bad++;
            $display("FAIL %s_writes: idx=%0d n=%0d took=%0d want n=%0d", nm,
                     m, we_a.size(), k, len);
        end
        total++;
        if (rsrdy_we != 0 || prot_err != 0) begin
            bad++;
            $display("FAIL %s_protocol: rdy_in_stb=%0d prot=%0d want 0 0", nm,
                     rsrdy_we, prot_err);
        end
        total++;
        if (done_cnt != 1 || done_ab !== 1'b0 || oe_q.size() != 0 ||
            sv_q.size() != 0 || first_act - st_cyc != 1) begin
            bad++;
            $display("FAIL %s_done: cnt=%0d ab=%b oe=%0d act0=%0d want 1 0 0 1",
                     nm, done_cnt, done_ab, oe_q.size(), first_act - st_cyc);
        end
    endtask

    task automatic test_stall();
        int serr, c;
        clear_mon();
        sv_rdy = 1'b0;
        start_cmd(SS_DIR_SAVE, 2);
        for (c = 0; c < 50 && sv_vld !== 1'b1; c++) begin
            @(posedge clk); #1;
        end
        serr = 0;
        repeat (10) begin
            @(negedge clk);
            if (sv_vld !== 1'b1 || sv_dat !== 8'hA0) serr++;
        end
        total++;
        if (c >= 50 || serr != 0) begin
            bad++;
            $display("FAIL stall_hold: errs=%0d wait=%0d want 0", serr, c);
        end
        total++;
        if (oe_q.size() != 1) begin
            bad++;
            $display("FAIL stall_oe_once: got %0d want 1", oe_q.size());
        end
        @(posedge clk); #1 sv_rdy = 1'b1;
        for (c = 0; c < 100 && done_cnt == 0; c++) begin
            @(posedge clk); #1;
        end
        sv_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (sv_q.size() != 2 || sv_q[0] !== 8'hA0 || sv_q[1] !== 8'hA1 ||
            oe_q.size() != 2 || done_cnt != 1) begin
            bad++;
            $display("FAIL stall_result: bytes=%0d oe=%0d done=%0d want 2 2 1",
                     sv_q.size(), oe_q.size(), done_cnt);
        end
    endtask

    task automatic test_len0();
        clear_mon();
        start_cmd(SS_DIR_SAVE, 0);
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (done_cnt != 1 || done_cyc - st_cyc != 1 || act_cyc != 0 ||
            oe_q.size() != 0 || we_a.size() != 0) begin
            bad++;
            $display("FAIL len0: done=%0d lat=%0d act=%0d want 1 1 0",
                     done_cnt, done_cyc - st_cyc, act_cyc);
        end
    endtask

    task automatic test_abort();
        int c, ab_cyc;
        clear_mon();
        sv_rdy = 1'b0;
        start_cmd(SS_DIR_SAVE, 5);
        for (c = 0; c < 50 && sv_vld !== 1'b1; c++) begin
            @(posedge clk); #1;
        end
        sv_rdy = 1'b1;
        @(posedge clk); #1 sv_rdy = 1'b0;
        for (c = 0; c < 50 && sv_vld !== 1'b1; c++) begin
            @(posedge clk); #1;
        end
        cmd_abort = 1'b1;
        ab_cyc = cyc;
        @(posedge clk); #1 cmd_abort = 1'b0;
        @(negedge clk);
        total++;
        if (sv_vld !== 1'b0 || c >= 50) begin
            bad++;
            $display("FAIL abort_vld_drop: got %b want 0", sv_vld);
        end
        for (c = 0; c < 50 && done_cnt == 0; c++) begin
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (done_cnt != 1 || done_ab !== 1'b1 || done_cyc - ab_cyc != STL + 1) begin
            bad++;
            $display("FAIL abort_done: cnt=%0d ab=%b lat=%0d want 1 1 %0d",
                     done_cnt, done_ab, done_cyc - ab_cyc, STL + 1);
        end
        total++;
        if (sv_q.size() != 1 || oe_q.size() != 2 || aborted !== 1'b1 ||
            ss_ctrl !== '0 || prot_err != 0) begin
            bad++;
            $display("FAIL abort_state: bytes=%0d oe=%0d ab=%b ctrl=%h want 1 2 1 0",
                     sv_q.size(), oe_q.size(), aborted, ss_ctrl);
        end
    endtask

    task automatic test_busy_start();
        clear_mon();
        sv_rdy = 1'b1;
        start_cmd(SS_DIR_SAVE, 3);
        repeat (5) @(posedge clk);
        #1;
        cmd_start = 1'b1;
        cmd_dir = SS_DIR_RST;
        cmd_len = 9'd7;
        @(posedge clk); #1 cmd_start = 1'b0;
        for (int c = 0; c < 100 && done_cnt == 0; c++) begin
            @(posedge clk); #1;
        end
        repeat (30) @(posedge clk);
        #1;
        sv_rdy = 1'b0;
        total++;
        if (sv_q.size() != 3 || we_a.size() != 0 || done_cnt != 1 ||
            done_ab !== 1'b0 || act_cyc != 2 * STL + 3 * (RDL + 2)) begin
            bad++;
            $display("FAIL busy_start: bytes=%0d we=%0d done=%0d act=%0d want 3 0 1 %0d",
                     sv_q.size(), we_a.size(), done_cnt, act_cyc,
                     2 * STL + 3 * (RDL + 2));
        end
    endtask

    task automatic test_reset_mid();
        int k;
        bit hs;
        clear_mon();
        start_cmd(SS_DIR_RST, 4);
        k = 0;
        for (int c = 0; c < 100 && we_a.size() < 2; c++) begin
            @(negedge clk);
            hs = rs_vld && rs_rdy;
            @(posedge clk); #1;
            if (hs) begin
                k++;
                rs_vld = 1'b0;
            end
            if (!rs_vld && k < 4) begin
                rs_vld = 1'b1;
                rs_dat = 8'(8'h50 + k);
            end
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (ss_ctrl !== '0 || busy !== 1'b0 || rs_rdy !== 1'b0 ||
            done !== 1'b0 || we_a.size() < 2) begin
            bad++;
            $display("FAIL reset_mid: ctrl=%h busy=%b wr=%0d want 0 0 >=2",
                     ss_ctrl, busy, we_a.size());
        end
        rs_vld = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (done_cnt != 0 || act_cyc != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_after: done=%0d act=%0d want 0 0",
                     done_cnt, act_cyc);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_save(3, 1'b0, "save3");
        test_stall();
        test_restore(4, 1'b1, "restore4");
        test_len0();
        test_save(256, 1'b1, "save256");
        test_abort();
        test_busy_start();
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 1) == 0)
                test_save($urandom_range(1, 24), 1'b1, "rnd_save");
            else
                test_restore($urandom_range(1, 24), 1'b0, "rnd_restore");
        end
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ss_sequencer.md
Name: ss_sequencer

Overview:
- Drives the save-state control bus (ss_ctrl) consumed by every mapper through map_hub.
- On an MCU command it freezes the mapper and then either walks register indices to dump state (save) or writes them back (restore).
- Data moves to and from the MCU over valid/ready streams.
- Sits between the MCU command interface and the ss_ctrl/ss_rdat path of the active mapper.

Parameters:
- ADDR_W, 8: width of the save-state register index.
- RD_LAT, 2: cycles from ss_oe assertion to valid ss_rdat from the mapper.
- SETTLE, 4: cycles ss_act is held before the first access, and after the last access before release.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_start  in  1  single-cycle command strobe.
- cmd_dir  in  1  0 = save (read mapper), 1 = restore (write mapper); sampled with cmd_start.
- cmd_len  in  ADDR_W+1  number of registers to transfer, 0..2^ADDR_W; sampled with cmd_start.
- cmd_abort  in  1  terminate the current operation.
- sv_dat  out  8  save stream data.
- sv_vld  out  1  save stream valid.
- sv_rdy  in  1  save stream ready.
- rs_dat  in  8  restore stream data.
- rs_vld  in  1  restore stream valid.
- rs_rdy  out  1  restore stream ready.
- ss_ctrl  out  `BW_SS_CTRL  packed bus {ss_act, ss_we, ss_oe, ss_addr[ADDR_W-1:0], ss_wdat[7:0]}.
- ss_rdat  in  8  mapper readback, selected through map_out.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  set with done when terminated by cmd_abort; held until the next cmd_start.

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE, taking effect immediately and independent of clk.
  - Reset mid-operation drops ss_act at once; no completion pulse is produced.
- States: IDLE, SETTLE_IN, RD_REQ, RD_WAIT, RD_PUSH, WR_GET, WR_STB, SETTLE_OUT, FIN.
- IDLE:
  - cmd_start with cmd_len = 0: go to FIN. done pulses the next cycle; ss_act is never asserted.
  - cmd_start with cmd_len > 0: latch dir and len, clear idx and aborted, set busy and ss_act, go to SETTLE_IN.
- SETTLE_IN: count SETTLE cycles, then go to RD_REQ (save) or WR_GET (restore).
- RD_REQ: ss_addr = idx and ss_oe = 1 for exactly one cycle, then RD_WAIT.
- RD_WAIT: wait RD_LAT-1 further cycles, then capture ss_rdat into sv_dat and go to RD_PUSH.
  - The first byte's capture edge is SETTLE+1+RD_LAT cycles after cmd_start.
- RD_PUSH: hold sv_vld = 1 with sv_dat stable until sv_rdy.
  - On the handshake: idx++. If idx == len, go to SETTLE_OUT; else go to RD_REQ.
  - ss_oe is never re-issued while stalled.
- WR_GET: rs_rdy = 1. On rs_vld, latch rs_dat into ss_wdat and go to WR_STB.
- WR_STB: ss_addr = idx and ss_we = 1 for exactly one cycle; idx++.
  - If idx == len, go to SETTLE_OUT; else go to WR_GET.
  - rs_rdy is 0 in this state, so the maximum rate is one byte per 2 cycles.
- SETTLE_OUT: hold ss_act for SETTLE cycles, then go to FIN.
- FIN: ss_act = 0, busy = 0, done = 1 for one cycle, return to IDLE.
- cmd_start while busy is ignored.
- cmd_abort in any non-IDLE state:
  - Finishes any in-progress single-cycle ss_we/ss_oe strobe, then goes to SETTLE_OUT with aborted = 1.
  - sv_vld drops immediately and the pending byte is discarded.
  - If cmd_abort and an sv handshake occur in the same cycle, the handshake completes and then the abort is taken.
- ss_we and ss_oe are mutually exclusive and are only ever high while ss_act = 1.
- idx is ADDR_W+1 bits, so len = 2^ADDR_W covers indices 0..255 with no wrap; ss_addr = idx[ADDR_W-1:0].
- Outputs are registered. ss_ctrl fields other than ss_act are 0 whenever no strobe is active.

Decomposition:
- defs.v gains:
  - SS_ACT, SS_WE, SS_OE bit positions and the SS_ADDR and SS_WDAT field ranges inside `BW_SS_CTRL;
  - the SS_DIR_SAVE/SS_DIR_RST constants;
  - the FSM state encodings.
- One sub-module, ss_delay_cnt: a loadable down-counter with a zero flag, shared by SETTLE_IN, SETTLE_OUT and RD_WAIT.

Test Plan:
- Save, len = 3, sv_rdy = 1, mapper model returns 8'hA0+addr:
  - sv emits A0, A1, A2;
  - ss_oe pulses at addr 0, 1, 2, each exactly one cycle;
  - done pulses once; ss_act spans from cycle 1 to the final SETTLE.
- Save, len = 2, sv_rdy held low for 10 cycles on byte 0:
  - sv_dat stays A0 and sv_vld stays 1;
  - only one ss_oe pulse occurs before release.
- Restore, len = 4, rs_dat = 11, 22, 33, 44 with rs_vld gaps:
  - ss_we pulses at addr 0..3 with ss_wdat matching each byte;
  - rs_rdy is 0 during WR_STB.
- cmd_len = 0 → done 1 cycle later, ss_act never asserted, no strobes.
- cmd_len = 256, save → addresses 0x00..0xFF with no wrap, 256 bytes, then done.
- Edge cases:
  - cmd_abort during RD_PUSH of byte 1 of 5 → sv_vld drops, SETTLE cycles pass, done = 1 with aborted = 1.
  - rst_n low mid-restore → ss_ctrl = 0 and busy = 0 immediately.
  - cmd_start while busy → ignored.
